// File: rtl/cp2_resp.sv
// cp2_resp: CP2 coprocessor responder. It holds c0..c7 and serves arithmetic, move-to and move-from strobes.
// Latency: ALU results and exceptions appear one cycle after the strobe. MFC data comes one cycle after fs. MUL takes 32 cycles.
// Backpressure: the abusy, tbusy and fbusy flags stall the CPU. A strobe that arrives while abusy is high is dropped.
//
// Ports:
//   clk, rst_            clock and asynchronous active-low reset
//   cp_irenable, cp_ir   instruction latch (op=[2:0] rd=[8:6] rs=[13:11] rt=[18:16])
//   cp2_as/ts/fs         arithmetic, to-coprocessor and from-coprocessor strobes
//   cp2_tds, cp2_tdata   write data for a pending MTC
//   cp2_a/t/fbusy        busy flags for each path
//   cp2_fds, cp2_fdata   MFC read data and its valid pulse
//   cp2_excs/exc/exccode exception status pulse, flag and code (0 none, 1 overflow, 2 undefined)
// Optional feature: define CP2_MUL_EN to build the 32-cycle shift-add multiplier.
// Without it, MUL is reported as an undefined op and abusy is tied to 0.
module cp2_resp (
  input  logic        clk,
  input  logic        rst_,
  input  logic        cp_irenable,
  input  logic [31:0] cp_ir,
  input  logic        cp2_as,
  input  logic        cp2_ts,
  input  logic        cp2_tds,
  input  logic [31:0] cp2_tdata,
  input  logic        cp2_fs,
  output logic        cp2_abusy,
  output logic        cp2_tbusy,
  output logic        cp2_fbusy,
  output logic        cp2_fds,
  output logic [31:0] cp2_fdata,
  output logic        cp2_excs,
  output logic        cp2_exc,
  output logic [3:0]  cp2_exccode
);

  localparam logic [2:0] OP_NOP = 3'b000;
  localparam logic [2:0] OP_ADD = 3'b001;
  localparam logic [2:0] OP_SUB = 3'b010;
  localparam logic [2:0] OP_AND = 3'b011;
  localparam logic [2:0] OP_OR  = 3'b100;
  localparam logic [2:0] OP_MUL = 3'b101;
  localparam logic [2:0] OP_MTC = 3'b110;
  localparam logic [2:0] OP_MFC = 3'b111;

  localparam logic [3:0] EXC_NONE  = 4'd0;
  localparam logic [3:0] EXC_OVF   = 4'd1;
  localparam logic [3:0] EXC_UNDEF = 4'd2;

  // Register file and instruction latch
  logic [31:0] c_q [0:7];
  logic [31:0] c_d [0:7];
  logic [31:0] ir_q, ir_d;

  // Transfer tracking
  logic        tbusy_q, tbusy_d;
  logic [2:0]  trt_q, trt_d;
  logic        fbusy_q, fbusy_d;
  logic [2:0]  frt_q, frt_d;
  logic [31:0] fdata_q, fdata_d;

  // Exception status, registered as a one-cycle pulse
  logic        excs_q, excs_d;
  logic        exc_q, exc_d;
  logic [3:0]  exccode_q, exccode_d;

`ifdef CP2_MUL_EN
  typedef enum logic {ST_IDLE, ST_MUL} state_t;
  state_t      state_q, state_d;
  logic [4:0]  count_q, count_d;
  logic [31:0] mcand_q, mcand_d;
  logic [31:0] mplier_q, mplier_d;
  logic [31:0] acc_q, acc_d;
  logic [2:0]  mrd_q, mrd_d;
`endif

  // Instruction fields
  logic [2:0] ir_op, ir_rd, ir_rs, ir_rt;
  assign ir_op = ir_q[2:0];
  assign ir_rd = ir_q[8:6];
  assign ir_rs = ir_q[13:11];
  assign ir_rt = ir_q[18:16];

  // These instruction bits carry no field this block decodes.
  logic unused_ir_bits;
  assign unused_ir_bits = ^{ir_q[31:19], ir_q[15:14], ir_q[10:9], ir_q[5:3]};

  // ALU datapath
  logic [31:0] opa, opb, sum, diff;
  logic        add_ovf, sub_ovf;
  assign opa  = c_q[ir_rs];
  assign opb  = c_q[ir_rt];
  assign sum  = opa + opb;
  assign diff = opa - opb;
  // Signed overflow happens when the result sign disagrees with what the operand signs allow.
  assign add_ovf = (opa[31] == opb[31]) && (sum[31]  != opa[31]);
  assign sub_ovf = (opa[31] != opb[31]) && (diff[31] != opa[31]);

  // An MFC waits while the multiplier still owes a write to the register it reads.
  logic mul_pend_frt;
`ifdef CP2_MUL_EN
  assign cp2_abusy    = (state_q == ST_MUL);
  assign mul_pend_frt = (state_q == ST_MUL) && (mrd_q == frt_q);
`else
  assign cp2_abusy    = 1'b0;
  assign mul_pend_frt = 1'b0;
`endif

  logic as_take;
  assign as_take = cp2_as & ~cp2_abusy;

  // Read data goes out in the cycle after fs, unless a multiply result is still pending.
  // fdata holds its last value between pulses.
  assign cp2_fds   = fbusy_q & ~mul_pend_frt;
  assign cp2_fdata = cp2_fds ? c_q[frt_q] : fdata_q;

  assign cp2_tbusy   = tbusy_q;
  assign cp2_fbusy   = fbusy_q;
  assign cp2_excs    = excs_q;
  assign cp2_exc     = exc_q;
  assign cp2_exccode = exccode_q;

  always_comb begin
    for (int i = 0; i < 8; i++) c_d[i] = c_q[i];
    ir_d      = cp_irenable ? cp_ir : ir_q;
    tbusy_d   = tbusy_q;
    trt_d     = trt_q;
    fbusy_d   = fbusy_q;
    frt_d     = frt_q;
    fdata_d   = cp2_fdata;
    excs_d    = 1'b0;
    exc_d     = 1'b0;
    exccode_d = EXC_NONE;
`ifdef CP2_MUL_EN
    state_d  = state_q;
    count_d  = count_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    mrd_d    = mrd_q;

    // Perform one shift-add step per cycle. Step 31 writes the low word.
    if (state_q == ST_MUL) begin
      acc_d    = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      count_d  = count_q + 5'd1;
      if (count_q == 5'd31) begin
        c_d[mrd_q] = acc_d;
        excs_d     = 1'b1;
        state_d    = ST_IDLE;
      end
    end
`endif

    // Arithmetic strobe
    if (as_take) begin
      excs_d = 1'b1;
      case (ir_op)
        OP_NOP: ;
        OP_ADD: begin
          if (add_ovf) begin
            exc_d     = 1'b1;
            exccode_d = EXC_OVF;
          end else begin
            c_d[ir_rd] = sum;
          end
        end
        OP_SUB: begin
          if (sub_ovf) begin
            exc_d     = 1'b1;
            exccode_d = EXC_OVF;
          end else begin
            c_d[ir_rd] = diff;
          end
        end
        OP_AND: c_d[ir_rd] = opa & opb;
        OP_OR:  c_d[ir_rd] = opa | opb;
        OP_MUL: begin
`ifdef CP2_MUL_EN
          // No status is reported now; the excs pulse comes when the multiply completes.
          excs_d   = 1'b0;
          state_d  = ST_MUL;
          count_d  = 5'd0;
          mcand_d  = opa;
          mplier_d = opb;
          acc_d    = 32'd0;
          mrd_d    = ir_rd;
`else
          exc_d     = 1'b1;
          exccode_d = EXC_UNDEF;
`endif
        end
        default: begin
          exc_d     = 1'b1;
          exccode_d = EXC_UNDEF;
        end
      endcase
    end

    // The pending MTC write is placed last so that it overrides a multiply result for the same register.
    if (tbusy_q && cp2_tds) begin
      c_d[trt_q] = cp2_tdata;
      tbusy_d    = 1'b0;
    end

    if (cp2_ts) begin
      if (ir_op == OP_MTC) begin
        tbusy_d = 1'b1;
        trt_d   = ir_rt;
      end else begin
        excs_d    = 1'b1;
        exc_d     = 1'b1;
        exccode_d = EXC_UNDEF;
      end
    end

    if (cp2_fds) fbusy_d = 1'b0;

    if (cp2_fs) begin
      if (ir_op == OP_MFC) begin
        fbusy_d = 1'b1;
        frt_d   = ir_rt;
      end else begin
        excs_d    = 1'b1;
        exc_d     = 1'b1;
        exccode_d = EXC_UNDEF;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      for (int i = 0; i < 8; i++) c_q[i] <= 32'd0;
      ir_q      <= 32'd0;
      tbusy_q   <= 1'b0;
      trt_q     <= 3'd0;
      fbusy_q   <= 1'b0;
      frt_q     <= 3'd0;
      fdata_q   <= 32'd0;
      excs_q    <= 1'b0;
      exc_q     <= 1'b0;
      exccode_q <= EXC_NONE;
`ifdef CP2_MUL_EN
      state_q  <= ST_IDLE;
      count_q  <= 5'd0;
      mcand_q  <= 32'd0;
      mplier_q <= 32'd0;
      acc_q    <= 32'd0;
      mrd_q    <= 3'd0;
`endif
    end else begin
      for (int i = 0; i < 8; i++) c_q[i] <= c_d[i];
      ir_q      <= ir_d;
      tbusy_q   <= tbusy_d;
      trt_q     <= trt_d;
      fbusy_q   <= fbusy_d;
      frt_q     <= frt_d;
      fdata_q   <= fdata_d;
      excs_q    <= excs_d;
      exc_q     <= exc_d;
      exccode_q <= exccode_d;
`ifdef CP2_MUL_EN
      state_q  <= state_d;
      count_q  <= count_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      mrd_q    <= mrd_d;
`endif
    end
  end

endmodule

// File: tb/tb_cp2_resp.sv
module tb_cp2_resp;

  localparam logic [2:0] OP_NOP = 3'b000;
  localparam logic [2:0] OP_ADD = 3'b001;
  localparam logic [2:0] OP_SUB = 3'b010;
  localparam logic [2:0] OP_AND = 3'b011;
  localparam logic [2:0] OP_OR  = 3'b100;
  localparam logic [2:0] OP_MUL = 3'b101;
  localparam logic [2:0] OP_MTC = 3'b110;
  localparam logic [2:0] OP_MFC = 3'b111;

  logic        clk = 1'b0;
  logic        rst_;
  logic        cp_irenable, cp2_as, cp2_ts, cp2_tds, cp2_fs;
  logic [31:0] cp_ir, cp2_tdata;
  logic        cp2_abusy, cp2_tbusy, cp2_fbusy, cp2_fds, cp2_excs, cp2_exc;
  logic [31:0] cp2_fdata;
  logic [3:0]  cp2_exccode;

  int total = 0;
  int bad   = 0;

  // This is the architectural model of c0..c7.
  logic [31:0] m [0:7];

  cp2_resp dut (
    .clk(clk), .rst_(rst_), .cp_irenable(cp_irenable), .cp_ir(cp_ir),
    .cp2_as(cp2_as), .cp2_ts(cp2_ts), .cp2_tds(cp2_tds), .cp2_tdata(cp2_tdata),
    .cp2_fs(cp2_fs), .cp2_abusy(cp2_abusy), .cp2_tbusy(cp2_tbusy),
    .cp2_fbusy(cp2_fbusy), .cp2_fds(cp2_fds), .cp2_fdata(cp2_fdata),
    .cp2_excs(cp2_excs), .cp2_exc(cp2_exc), .cp2_exccode(cp2_exccode)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: observed=timeout required=finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] enc(input logic [2:0] op, input logic [2:0] rd,
                                      input logic [2:0] rs, input logic [2:0] rt);
    logic [31:0] w;
    w = $urandom;           // random filler in the bits the block does not decode
    w[2:0]   = op;
    w[8:6]   = rd;
    w[13:11] = rs;
    w[18:16] = rt;
    return w;
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h7FFF_FFFF;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'h0000_0001;
      default: return $urandom;
    endcase
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 8; i++) m[i] = 32'd0;
  endtask

  // Compute ALU results in full 64-bit signed arithmetic and report the expected exception.
  task automatic model_alu(input logic [2:0] op, input logic [2:0] rd, input logic [2:0] rs,
                           input logic [2:0] rt, output logic e, output logic [3:0] code);
    longint sa, sb, r;
    sa = longint'($signed(m[rs]));
    sb = longint'($signed(m[rt]));
    e = 1'b0;
    code = 4'd0;
    r = 0;
    case (op)
      OP_ADD, OP_SUB: begin
        r = (op == OP_ADD) ? sa + sb : sa - sb;
        if (r > 64'sd2147483647 || r < -64'sd2147483648) begin
          e = 1'b1;
          code = 4'd1;
        end else begin
          m[rd] = r[31:0];
        end
      end
      OP_AND: m[rd] = m[rs] & m[rt];
      OP_OR:  m[rd] = m[rs] | m[rt];
      default: ;
    endcase
  endtask

  // Every task below starts and ends on a falling edge.
  task automatic load_ir(input logic [31:0] w);
    cp_irenable = 1'b1;
    cp_ir = w;
    @(negedge clk);
    cp_irenable = 1'b0;
  endtask

  task automatic do_mtc(input logic [2:0] rt, input logic [31:0] v, input int dly);
    load_ir(enc(OP_MTC, 3'($urandom), 3'($urandom), rt));
    cp2_ts = 1'b1;
    @(negedge clk);
    cp2_ts = 1'b0;
    chk("mtc_tbusy_set", cp2_tbusy, 1);
    for (int i = 0; i < dly; i++) begin
      @(negedge clk);
      chk("mtc_tbusy_wait", cp2_tbusy, 1);
    end
    cp2_tds = 1'b1;
    cp2_tdata = v;
    @(negedge clk);
    cp2_tds = 1'b0;
    cp2_tdata = $urandom;
    chk("mtc_tbusy_clr", cp2_tbusy, 0);
    m[rt] = v;
  endtask

  task automatic do_mfc(input logic [2:0] rt, output logic [31:0] v, output int lat);
    load_ir(enc(OP_MFC, 3'($urandom), 3'($urandom), rt));
    cp2_fs = 1'b1;
    @(negedge clk);
    cp2_fs = 1'b0;
    lat = 1;
    while (!cp2_fds && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    if (!cp2_fds) lat = -1;
    v = cp2_fdata;
    @(negedge clk);
    chk("mfc_fds_pulse", cp2_fds, 0);
    chk("mfc_fbusy_clr", cp2_fbusy, 0);
    chk("mfc_fdata_hold", cp2_fdata, v);
  endtask

  task automatic do_arith(input logic [31:0] w, input logic e, input logic [3:0] code);
    load_ir(w);
    cp2_as = 1'b1;
    @(negedge clk);
    cp2_as = 1'b0;
    chk("as_excs", cp2_excs, 1);
    chk("as_exc", cp2_exc, e);
    chk("as_exccode", cp2_exccode, code);
    @(negedge clk);
    chk("as_excs_pulse", cp2_excs, 0);
  endtask

  logic [31:0] v;
  int          lat;
  logic        e;
  logic [3:0]  code;
  logic [2:0]  op_r, rd_r, rs_r, rt_r;
  int          abusy_cnt, abusy_last, fds_cyc, excs_cnt, exc_seen, fbusy_gap;
  logic [31:0] fval;
  logic [63:0] prod;

  initial begin
    rst_ = 1'b0;
    cp_irenable = 0; cp_ir = 0; cp2_as = 0; cp2_ts = 0; cp2_tds = 0; cp2_tdata = 0; cp2_fs = 0;
    model_clear();
    repeat (2) @(negedge clk);
    chk("rst_flags", {25'd0, cp2_abusy, cp2_tbusy, cp2_fbusy, cp2_fds, cp2_excs, cp2_exc}, 0);
    chk("rst_exccode", cp2_exccode, 0);
    chk("rst_fdata", cp2_fdata, 0);
    rst_ = 1'b1;
    @(negedge clk);

    // ADD with no overflow, then read the result back
    do_mtc(3'd1, 32'd5, 0);
    do_mtc(3'd2, 32'd7, 0);
    model_alu(OP_ADD, 3'd3, 3'd1, 3'd2, e, code);
    do_arith(enc(OP_ADD, 3'd3, 3'd1, 3'd2), e, code);
    do_mfc(3'd3, v, lat);
    chk("add_mfc_lat", lat, 1);
    chk("add_mfc_data", v, m[3]);
    chk("add_result_12", v, 32'd12);

    // Signed overflow must leave c3 untouched
    do_mtc(3'd1, 32'h7FFF_FFFF, 1);
    do_mtc(3'd2, 32'd1, 0);
    model_alu(OP_ADD, 3'd3, 3'd1, 3'd2, e, code);
    do_arith(enc(OP_ADD, 3'd3, 3'd1, 3'd2), e, code);
    do_mfc(3'd3, v, lat);
    chk("ovf_c3_kept", v, m[3]);

    // MTC whose tds comes three cycles after ts
    do_mtc(3'd6, 32'hDEAD_BEEF, 2);
    do_mfc(3'd6, v, lat);
    chk("mtc_c6", v, m[6]);

    // SUB overflow
    do_mtc(3'd1, 32'h8000_0000, 0);
    model_alu(OP_SUB, 3'd5, 3'd1, 3'd2, e, code);
    do_arith(enc(OP_SUB, 3'd5, 3'd1, 3'd2), e, code);

    // Mismatched strobes and NOP
    do_arith(enc(OP_MTC, 3'd3, 3'd1, 3'd2), 1'b1, 4'd2);
    chk("as_mtc_no_tbusy", cp2_tbusy, 0);
    do_arith(enc(OP_MFC, 3'd3, 3'd1, 3'd2), 1'b1, 4'd2);
    chk("as_mfc_no_fbusy", cp2_fbusy, 0);
    do_arith(enc(OP_NOP, 3'd3, 3'd1, 3'd2), 1'b0, 4'd0);
    load_ir(enc(OP_ADD, 3'd6, 3'd6, 3'd6));
    cp2_ts = 1'b1;
    @(negedge clk);
    cp2_ts = 1'b0;
    chk("ts_alu_exc", {cp2_excs, cp2_exc, cp2_exccode}, {2'b11, 4'd2});
    chk("ts_alu_no_tbusy", cp2_tbusy, 0);
    cp2_tds = 1'b1;
    cp2_tdata = 32'h1234_5678;           // a stray tds must not write anything
    @(negedge clk);
    cp2_tds = 1'b0;
    load_ir(enc(OP_AND, 3'd6, 3'd6, 3'd6));
    cp2_fs = 1'b1;
    @(negedge clk);
    cp2_fs = 1'b0;
    chk("fs_alu_exc", {cp2_excs, cp2_exc, cp2_exccode}, {2'b11, 4'd2});
    chk("fs_alu_no_fbusy", {cp2_fbusy, cp2_fds}, 0);
    do_mfc(3'd6, v, lat);
    chk("mismatch_c6_kept", v, m[6]);
    do_mfc(3'd3, v, lat);
    chk("mismatch_c3_kept", v, m[3]);

`ifdef CP2_MUL_EN
    // Multiply, with an MFC of the destination issued mid-way and a dropped as
    do_mtc(3'd1, 32'h0001_0000, 0);
    do_mtc(3'd2, 32'h0001_0001, 0);
    prod = 64'(m[1]) * 64'(m[2]);
    load_ir(enc(OP_MUL, 3'd4, 3'd1, 3'd2));
    cp2_as = 1'b1;
    abusy_cnt = 0; abusy_last = -1; fds_cyc = -1; excs_cnt = 0; exc_seen = 0; fbusy_gap = 0; fval = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (i == 0) cp2_as = 1'b0;
      if (cp2_abusy) begin abusy_cnt++; abusy_last = i; end
      if (cp2_excs) begin excs_cnt++; if (cp2_exc) exc_seen = 1; end
      if (cp2_fds && fds_cyc < 0) begin fds_cyc = i; fval = cp2_fdata; end
      if (i >= 6 && fds_cyc < 0 && !cp2_fbusy) fbusy_gap = 1;
      if (i == 4) begin cp_irenable = 1'b1; cp_ir = enc(OP_MFC, 3'd0, 3'd0, 3'd4); end
      if (i == 5) begin cp_irenable = 1'b0; cp2_fs = 1'b1; end
      if (i == 6) cp2_fs = 1'b0;
      if (i == 10) cp2_as = 1'b1;
      if (i == 11) cp2_as = 1'b0;
    end
    m[4] = prod[31:0];
    chk("mul_abusy_cycles", abusy_cnt, 32);
    chk("mul_fds_after_done", fds_cyc, abusy_last + 1);
    chk("mul_fdata", fval, m[4]);
    chk("mul_fdata_value", fval, 32'h0001_0000);
    chk("mul_excs_once", excs_cnt, 1);
    chk("mul_no_exc", exc_seen, 0);
    chk("mul_fbusy_held", fbusy_gap, 0);

    // An MTC write that lands on the same edge as the multiply result must win
    load_ir(enc(OP_MUL, 3'd4, 3'd2, 3'd2));
    cp2_as = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (i == 0) cp2_as = 1'b0;
      if (i == 2) begin cp_irenable = 1'b1; cp_ir = enc(OP_MTC, 3'd0, 3'd0, 3'd4); end
      if (i == 3) begin cp_irenable = 1'b0; cp2_ts = 1'b1; end
      if (i == 4) cp2_ts = 1'b0;
      if (i == 31) begin cp2_tds = 1'b1; cp2_tdata = 32'hA5A5_A5A5; end
      if (i == 32) cp2_tds = 1'b0;
    end
    m[4] = 32'hA5A5_A5A5;
    do_mfc(3'd4, v, lat);
    chk("mul_mtc_collide", v, m[4]);
`else
    // Without the multiplier, MUL is an undefined op and abusy never rises
    do_arith(enc(OP_MUL, 3'd4, 3'd1, 3'd2), 1'b1, 4'd2);
    abusy_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (cp2_abusy) abusy_cnt++;
    end
    chk("nomul_abusy", abusy_cnt, 0);
    do_mfc(3'd4, v, lat);
    chk("nomul_c4_kept", v, m[4]);
`endif

    // Random ALU traffic against the model
    for (int r = 0; r < 8; r++) do_mtc(3'(r), pick(), $urandom_range(0, 3));
    for (int k = 0; k < 40; k++) begin
      if ($urandom_range(0, 2) == 0) do_mtc(3'($urandom), pick(), $urandom_range(0, 3));
      op_r = 3'($urandom_range(1, 4));
      rd_r = 3'($urandom);
      rs_r = 3'($urandom);
      rt_r = 3'($urandom);
      model_alu(op_r, rd_r, rs_r, rt_r, e, code);
      do_arith(enc(op_r, rd_r, rs_r, rt_r), e, code);
      do_mfc(rd_r, v, lat);
      chk("rand_mfc", v, m[rd_r]);
    end

    // Reset in the middle of a transfer aborts it
    load_ir(enc(OP_MTC, 3'd0, 3'd0, 3'd6));
    cp2_ts = 1'b1;
    @(negedge clk);
    cp2_ts = 1'b0;
    #2 rst_ = 1'b0;
    #1 chk("rst_mtc_tbusy", cp2_tbusy, 0);
    @(negedge clk);
    rst_ = 1'b1;
    model_clear();
    cp2_tds = 1'b1;
    cp2_tdata = 32'hCAFE_F00D;
    @(negedge clk);
    cp2_tds = 1'b0;
    do_mfc(3'd6, v, lat);
    chk("rst_mtc_c6", v, m[6]);

`ifdef CP2_MUL_EN
    // Reset ten cycles into a multiply
    do_mtc(3'd1, 32'h0001_0000, 0);
    do_mtc(3'd2, 32'h0001_0001, 0);
    load_ir(enc(OP_MUL, 3'd4, 3'd1, 3'd2));
    cp2_as = 1'b1;
    @(negedge clk);
    cp2_as = 1'b0;
    repeat (9) @(negedge clk);
    chk("mul_busy_before_rst", cp2_abusy, 1);
    #2 rst_ = 1'b0;
    #1 chk("rst_mul_abusy", cp2_abusy, 0);
    @(negedge clk);
    rst_ = 1'b1;
    model_clear();
    repeat (40) @(negedge clk);
    do_mfc(3'd4, v, lat);
    chk("rst_mul_c4", v, m[4]);
    chk("rst_mul_abusy_idle", cp2_abusy, 0);
`endif
    do_mfc(3'd1, v, lat);
    chk("rst_c1_clear", v, m[1]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
